// File: rtl/switch_conditioner.sv
// Board switch conditioner: 2-FF synchronizer, per-bit debounce, edge pulses
// and sticky change flags for the memory-mapped switch input.
module switch_conditioner #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_switches_raw,
  input  logic             i_clear_changed,
  output logic [WIDTH-1:0] o_switches,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic [WIDTH-1:0] o_changed,
  output logic             o_any_changed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_switches;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [WIDTH-1:0] r_changed;
  logic [CW-1:0]    r_cnt [WIDTH];

  logic [WIDTH-1:0] w_differ;
  logic [WIDTH-1:0] w_accept;
  logic [CW-1:0]    w_cnt_next [WIDTH];
  logic [WIDTH-1:0] w_rise_next;
  logic [WIDTH-1:0] w_fall_next;

  // A bit accepts its new level on the DEBOUNCE_CYCLES-th consecutive differing cycle.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign w_differ[gi]   = r_sync2[gi] ^ r_switches[gi];
      assign w_accept[gi]   = w_differ[gi] && (r_cnt[gi] == CNT_LAST);
      assign w_cnt_next[gi] = (!w_differ[gi] || w_accept[gi]) ? '0 : r_cnt[gi] + CW'(1);
    end
  endgenerate

  assign w_rise_next = w_accept & r_sync2;
  assign w_fall_next = w_accept & ~r_sync2;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_switches <= '0;
      r_rise     <= '0;
      r_fall     <= '0;
      r_changed  <= '0;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1    <= i_switches_raw;
      r_sync2    <= r_sync1;
      r_switches <= r_switches ^ w_accept;
      r_rise     <= w_rise_next;
      r_fall     <= w_fall_next;
      // A new edge on the same cycle as a clear wins, so no change is lost.
      r_changed  <= (r_changed & ~{WIDTH{i_clear_changed}}) | w_rise_next | w_fall_next;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= w_cnt_next[i];
    end
  end

  assign o_switches    = r_switches;
  assign o_rise        = r_rise;
  assign o_fall        = r_fall;
  assign o_changed     = r_changed;
  assign o_any_changed = |r_changed;

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench for switch_conditioner with WIDTH=4, DEBOUNCE_CYCLES=4.
module tb_switch_conditioner;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] raw;
  logic         clr;
  logic [W-1:0] sw;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic [W-1:0] chg;
  logic         any_chg;

  int n_checks;
  int n_fail;

  switch_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_switches_raw (raw),
    .i_clear_changed(clr),
    .o_switches     (sw),
    .o_rise         (rise),
    .o_fall         (fall),
    .o_changed      (chg),
    .o_any_changed  (any_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [W-1:0] raw_val);
    raw = raw_val;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  int rise_cnt;
  int rise_idx;
  logic [8:0] bounce;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    raw = 4'hF;
    clr = 1'b0;

    // 1) power-up with switches held high, then async reset mid-run
    step(2);
    rst = 1'b0;
    step(6);
    check("pwrup_sw", sw, 4'hF);
    step(2);
    #2 rst = 1'b1;
    #1;
    check("async_rst_sw", sw, 4'h0);
    check("async_rst_chg", chg, 4'h0);
    check("async_rst_any", any_chg, 1'b0);
    step(2);
    rst = 1'b0;
    step(5);
    check("rst_rel_sw_e5", sw, 4'h0);
    step(1);
    check("rst_rel_sw_e6", sw, 4'hF);
    check("rst_rel_rise", rise, 4'hF);
    check("rst_rel_chg", chg, 4'hF);
    check("rst_rel_any", any_chg, 1'b1);
    step(1);
    check("rst_rel_rise_gone", rise, 4'h0);

    // 2) clean 0->1 on bit 2
    do_reset(4'h0);
    step(3);
    check("zero_state_sw", sw, 4'h0);
    raw = 4'b0100;
    step(5);
    check("b2_sw_e5", sw, 4'h0);
    step(1);
    check("b2_sw_e6", sw, 4'b0100);
    check("b2_rise", rise, 4'b0100);
    check("b2_fall", fall, 4'h0);
    check("b2_chg", chg, 4'b0100);
    step(1);
    check("b2_rise_gone", rise, 4'h0);

    // 3) 3-cycle glitch rejected, 4-cycle pulse accepted on bit 0
    raw = 4'b0101;
    step(3);
    raw = 4'b0100;
    step(8);
    check("glitch3_sw", sw, 4'b0100);
    check("glitch3_chg", chg, 4'b0100);
    raw = 4'b0101;
    step(4);
    raw = 4'b0100;
    step(1);
    check("pulse4_sw_e4", sw, 4'b0100);
    step(1);
    check("pulse4_sw_e5", sw, 4'b0101);
    check("pulse4_rise", rise, 4'b0001);
    step(10);
    check("pulse4_fall_back", sw, 4'b0100);

    // 4) bounce on bit 1: only the final 4-long run is accepted
    bounce   = 9'b111101101;  // applied LSB first: 1,0,1,1,0,1,1,1,1
    rise_cnt = 0;
    rise_idx = -1;
    for (int j = 0; j < 20; j++) begin
      raw[1] = (j < 9) ? bounce[j] : 1'b1;
      step(1);
      if (rise[1]) begin
        rise_cnt++;
        rise_idx = j;
      end
    end
    check("bounce_rise_count", rise_cnt, 1);
    check("bounce_rise_edge", rise_idx, 10);
    check("bounce_sw", sw, 4'b0110);
    check("bounce_chg", chg, 4'b0111);

    // 5) clear_changed colliding with fall[3]
    raw = 4'b1110;
    step(6);
    check("b3_up_sw", sw, 4'b1110);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("clr_chg", chg, 4'h0);
    check("clr_any", any_chg, 1'b0);
    raw = 4'b0110;
    step(5);
    clr = 1'b1;
    step(1);
    check("coll_fall", fall, 4'b1000);
    check("coll_chg_kept", chg, 4'b1000);
    step(1);
    clr = 1'b0;
    check("coll_clr_chg", chg, 4'h0);
    check("coll_clr_any", any_chg, 1'b0);

    // 6) bits 0 and 3 toggle together, up then down
    raw = 4'b1111;
    step(5);
    check("multi_up_sw_e5", sw, 4'b0110);
    step(1);
    check("multi_up_sw", sw, 4'b1111);
    check("multi_up_rise", rise, 4'b1001);
    check("multi_up_fall", fall, 4'h0);
    check("multi_up_chg", chg, 4'b1001);
    check("multi_up_any", any_chg, 1'b1);
    raw = 4'b0110;
    step(6);
    check("multi_dn_sw", sw, 4'b0110);
    check("multi_dn_fall", fall, 4'b1001);
    check("multi_dn_rise", rise, 4'h0);
    check("multi_dn_chg", chg, 4'b1001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
